// File: rtl/gray_pkg.sv
// Shared mode encodings and code-conversion helpers for the Gray/binary stream.
// Helpers work on zero-extended MAX_W vectors, so one function body serves every WIDTH up to MAX_W.
package gray_pkg;

  localparam int MAX_W = 64;

  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;

  typedef logic [MAX_W-1:0] code_t;

  function automatic code_t bin2gray(code_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits leave the prefix XOR unaffected for narrower codes.
  function automatic code_t gray2bin(code_t g);
    code_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic hamming_gt1(code_t a, code_t b);
    code_t d;
    d = a ^ b;
    return (d & (d - code_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_binary_stream_if.sv
// Valid/ready stream bundle for the Gray/binary converter.
// The slave modport is the converter side; master is the source/sink side.
interface gray_binary_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_code;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_code;
  logic             out_mode;
  logic             out_adj_err;

  modport master (
    output in_valid, in_code, in_mode, out_ready,
    input  in_ready, out_valid, out_code, out_mode, out_adj_err
  );

  modport slave (
    input  in_valid, in_code, in_mode, out_ready,
    output in_ready, out_valid, out_code, out_mode, out_adj_err
  );
endinterface

// File: rtl/gray_adj_checker.sv
// Gray adjacency history and saturating error counter.
// Flags an accepted Gray beat that differs from the previous Gray beat in more than one bit.
import gray_pkg::*;

module gray_adj_checker #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     code,
  input  logic                 clr_err,
  output logic                 adj_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] prev_gray;
  logic             hist_valid;

  assign adj_err = (mode == MODE_GRAY2BIN) & hist_valid &
                   hamming_gt1(code_t'(code), code_t'(prev_gray));

  // A binary beat breaks the Gray sequence, so history restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray  <= '0;
      hist_valid <= 1'b0;
    end else if (accept) begin
      if (mode == MODE_GRAY2BIN) begin
        prev_gray  <= code;
        hist_valid <= 1'b1;
      end else begin
        hist_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (accept && adj_err && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/gray_binary_stream.sv
// Streaming Gray<->binary converter with a one-deep registered output stage.
// Mode is chosen per beat; optional Gray adjacency checking counts bad steps.
import gray_pkg::*;

module gray_binary_stream #(
  parameter int WIDTH     = 8,
  parameter int CHECK_ADJ = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  gray_binary_stream_if.slave  bus
);

  logic             accept;
  logic             adj_err;
  logic [WIDTH-1:0] conv;

  assign bus.in_ready = en & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  assign conv = (bus.in_mode == MODE_GRAY2BIN)
              ? WIDTH'(gray2bin(code_t'(bus.in_code)))
              : WIDTH'(bin2gray(code_t'(bus.in_code)));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_code    <= '0;
      bus.out_mode    <= 1'b0;
      bus.out_adj_err <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_code    <= conv;
      bus.out_mode    <= bus.in_mode;
      bus.out_adj_err <= adj_err;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end

  generate
    if (CHECK_ADJ != 0) begin : g_adj
      gray_adj_checker #(
        .WIDTH     (WIDTH),
        .ERR_CNT_W (ERR_CNT_W)
      ) u_adj (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .mode    (bus.in_mode),
        .code    (bus.in_code),
        .clr_err (clr_err),
        .adj_err (adj_err),
        .err_cnt (err_cnt)
      );
    end else begin : g_no_adj
      assign adj_err = 1'b0;
      assign err_cnt = '0;
    end
  endgenerate

endmodule

// File: tb/tb_gray_binary_stream.sv
// Scoreboard bench for gray_binary_stream: directed beats push expectations,
// a negedge monitor pops and compares every transferred output beat.
module tb_gray_binary_stream;

  localparam int W  = 8;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr_err;
  logic [EW-1:0] err_cnt;

  gray_binary_stream_if #(.WIDTH(W)) bus ();

  gray_binary_stream #(
    .WIDTH     (W),
    .CHECK_ADJ (1),
    .ERR_CNT_W (EW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr_err (clr_err),
    .err_cnt (err_cnt),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] code;
    logic         mode;
    logic         adj;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the parity of the Gray bits at and above it.
  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got code %0h with no expected beat",
                 bus.out_code);
      end else begin
        e = exp_q.pop_front();
        check("out_code", int'(bus.out_code), int'(e.code));
        check("out_mode", int'(bus.out_mode), int'(e.mode));
        check("out_adj_err", int'(bus.out_adj_err), int'(e.adj));
      end
    end
  end

  task automatic send(input logic [W-1:0] code, input logic mode,
                      input logic [W-1:0] ecode, input logic eadj,
                      input bit push = 1'b1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_mode  = mode;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (push) exp_q.push_back(beat_t'{ecode, mode, eadj});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got no accept for code %0h expected accept", code);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int start;

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    clr_err       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_code", int'(bus.out_code), 0);
    check("rst_out_mode", int'(bus.out_mode), 0);
    check("rst_out_adj_err", int'(bus.out_adj_err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);

    send(8'h5A, 1'b0, 8'h77, 1'b0);
    send(8'h77, 1'b1, 8'h5A, 1'b0);

    start = cyc;
    for (int i = 0; i < 256; i++) begin
      send(W'(i), 1'b0, m_b2g(W'(i)), 1'b0);
      send(m_b2g(W'(i)), 1'b1, m_g2b(m_b2g(W'(i))), 1'b0);
    end
    check("throughput_cycles", cyc - start, 512);
    drain();

    pulse_rst();
    send(8'h00, 1'b1, 8'h00, 1'b0);
    send(8'h01, 1'b1, 8'h01, 1'b0);
    send(8'h03, 1'b1, 8'h02, 1'b0);
    send(8'h05, 1'b1, 8'h06, 1'b1);
    send(8'h05, 1'b1, 8'h06, 1'b0);
    check("err_cnt_adj", int'(err_cnt), 1);
    send(8'h10, 1'b0, 8'h18, 1'b0);
    send(8'hFF, 1'b1, 8'hAA, 1'b0);
    check("err_cnt_after_bin", int'(err_cnt), 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("err_cnt_clr", int'(err_cnt), 0);
    clr_err = 1'b1;
    send(8'h00, 1'b1, 8'h00, 1'b1);
    clr_err = 1'b0;
    check("err_cnt_clr_priority", int'(err_cnt), 0);
    drain();

    bus.out_ready = 1'b0;
    send(8'h0F, 1'b0, 8'h08, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_code  = 8'h33;
    bus.in_mode  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_out_code", int'(bus.out_code), 8'h08);
      check("bp_out_mode", int'(bus.out_mode), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'h33, 1'b0, 8'h2A, 1'b0);
    send(8'hC0, 1'b1, 8'h80, 1'b0);
    drain();

    bus.out_ready = 1'b0;
    send(8'h01, 1'b0, 8'h01, 1'b0);
    en           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code  = 8'h02;
    bus.in_mode  = 1'b0;
    @(negedge clk);
    check("en_in_ready_held", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("en_in_ready_drain", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      check("en_out_valid", int'(bus.out_valid), 0);
      check("en_in_ready_idle", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    send(8'h02, 1'b0, 8'h03, 1'b0);
    drain();

    bus.out_ready = 1'b0;
    send(8'h44, 1'b0, 8'h66, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", int'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    pulse_rst();
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_out_code", int'(bus.out_code), 0);
    check("mid_rst_out_mode", int'(bus.out_mode), 0);
    check("mid_rst_out_adj_err", int'(bus.out_adj_err), 0);
    check("mid_rst_err_cnt", int'(err_cnt), 0);
    bus.out_ready = 1'b1;

    send(8'h00, 1'b1, 8'h00, 1'b0);
    send(8'h03, 1'b1, 8'h02, 1'b1);
    send(8'h00, 1'b1, 8'h00, 1'b1);
    send(8'h03, 1'b1, 8'h02, 1'b1);
    send(8'h00, 1'b1, 8'h00, 1'b1);
    send(8'h03, 1'b1, 8'h02, 1'b1);
    check("err_cnt_sat", int'(err_cnt), 3);
    send(8'h00, 1'b1, 8'h00, 1'b1);
    check("err_cnt_sat_hold", int'(err_cnt), 3);
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_binary_stream.md
Name: gray_binary_stream

Overview:
Streaming, parametrised Gray/binary code converter with a valid/ready handshake on both sides and a per-beat conversion mode.
Adds a registered output stage with back-pressure, a global enable and a Gray-adjacency checker with a saturating error counter.
Sits between a code source (counter, encoder, CDC pointer) and its consumer, replacing fixed-width, unhandshaked conversion.

Parameters:
WIDTH, 8, code width in bits (≥2)
CHECK_ADJ, 1, 1 = enable Gray adjacency checking on Gray-to-binary beats; 0 = err outputs tied 0
ERR_CNT_W, 8, width of saturating adjacency-error counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  conversion enable; 0 blocks input acceptance
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_code  input  WIDTH  code to convert
in_mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts output beat
out_code  output  WIDTH  converted code
out_mode  output  1  mode of the beat in out_code
out_adj_err  output  1  this output beat violated Gray adjacency
clr_err  input  1  clear err_cnt
err_cnt  output  ERR_CNT_W  saturating count of adjacency errors

Behaviour:
- Reset: out_valid=0, out_code=0, out_mode=0, out_adj_err=0, err_cnt=0, history invalid. Reset mid-stream discards the held beat; no output beat is produced for it.
- in_ready = en & (~out_valid | out_ready), purely combinational. Accept = in_valid & in_ready.
- Latency: 1 cycle. A beat accepted at edge N is presented at out_* after edge N. Full throughput of 1 beat/cycle when out_ready=1.
- Binary-to-Gray: out = in ^ (in >> 1).
- Gray-to-binary: out[WIDTH-1] = in[WIDTH-1]; out[i] = out[i+1] ^ in[i] (prefix XOR, single cycle).
- Hold: when out_valid=1 & out_ready=0, out_code, out_mode and out_adj_err stay stable. A beat is not dropped or duplicated.
- Output update: on out_ready=1 with no accept, out_valid drops to 0. When an output is consumed and a new beat is accepted in the same cycle, the output is replaced next edge.
- en=0: no new beats are accepted. A held output beat still drains normally.
- Adjacency checker (CHECK_ADJ=1):
  - Keeps prev_gray and hist_valid.
  - On an accepted mode-1 beat with hist_valid=1, set the beat's adj_err = (popcount(in ^ prev_gray) > 1). A Hamming distance of 0 (repeat) is legal.
  - On any accepted mode-1 beat, prev_gray ← in and hist_valid ← 1.
  - An accepted mode-0 beat sets hist_valid ← 0. The first Gray beat after reset or a mode-0 beat never flags.
- err_cnt:
  - Increments by 1 when an adj_err beat is accepted (at acceptance, not output).
  - Saturates at all-ones.
  - clr_err=1 zeroes it, and takes priority over a same-cycle increment.
  - rst takes priority over everything.
- CHECK_ADJ=0: out_adj_err=0, err_cnt=0, history logic removed.

Decomposition:
- Shared package gray_pkg:
  - mode constants MODE_BIN2GRAY=1'b0, MODE_GRAY2BIN=1'b1
  - functions bin2gray(), gray2bin(), hamming_gt1(), all parametrised by width.
- One natural sub-module, gray_adj_checker (prev_gray, hist_valid, error flag, saturating counter), instantiated under CHECK_ADJ.

Test Plan:
1. Basic conversion (WIDTH=8, en=1, out_ready=1): in_code=0x5A, mode 0 -> out_code=0x77 one cycle later. Then in_code=0x77, mode 1 -> out_code=0x5A, out_adj_err=0.
2. Round trip: sweep 0..255 in mode 0, feed each output back in mode 1 -> every result equals the original value. Throughput is 1 beat/cycle with no gaps.
3. Adjacency: mode-1 beats 0x00, 0x01, 0x03, 0x05, 0x05 -> out_adj_err = 0,0,0,1,0 and err_cnt=1. Insert one mode-0 beat, then mode-1 0xFF -> no flag. clr_err -> err_cnt=0.
4. Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_code/out_mode stable, one beat held. Release -> beats emerge in order with none lost.
5. Enable: en=0 with in_valid=1 -> in_ready=0 and no new outputs while the held beat drains. en=1 resumes.
6. Reset and saturation:
   - rst asserted while out_valid=1 -> next cycle all outputs 0.
   - ERR_CNT_W=2: force 5 errors -> err_cnt=3, holds at 3.
